seq_divider_8_4: RTL
====================

Name: seq_divider_8_4

Overview:
- Sequential restoring divider. Computes an unsigned 8-bit dividend divided by a 4-bit divisor, producing an 8-bit quotient and a 4-bit remainder.
- It is the inverse-direction companion to the 4x4 Vedic multiplier datapath: it recovers operands from products.
- One quotient bit per clock. Uses a start/done handshake so it can sit behind the multiplier in the arithmetic test chain.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width.
- DIVISOR_W, 4, divisor and remainder width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- start  input  1  request pulse; accepted only when busy=0.
- dividend  input  DIVIDEND_W  numerator, sampled on the accepted start cycle.
- divisor  input  DIVISOR_W  denominator, sampled on the accepted start cycle.
- quotient  output  DIVIDEND_W  registered result, held until next accept.
- remainder  output  DIVISOR_W  registered result, held until next accept.
- busy  output  1  high from the cycle after accept until the cycle done is asserted.
- done  output  1  single-cycle pulse; results are valid in this cycle.
- div_by_zero  output  1  registered flag for the last operation, held with the results.
- check_err  output  1  self-check mismatch flag (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, check_err=0.
  - Reset overrides everything, including an operation in progress. The partial result is discarded and no done is issued.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 with divisor!=0: latch the dividend into the shift register Q, latch the divisor into D, clear the partial remainder R, set counter=DIVIDEND_W-1, go to RUN.
  - start=1 with divisor==0: go to FIN with the zero flag set internally.
  - start=0: stay in IDLE.
- RUN, each cycle:
  - R_t = {R[DIVISOR_W-1:0], Q[MSB]}. R is DIVISOR_W+1 bits wide to hold the shifted partial remainder.
  - Q shifts left.
  - If R_t >= D: R = R_t - D and Q[0]=1. Otherwise R = R_t and Q[0]=0.
  - When counter==0, go to FIN; otherwise decrement the counter.
  - Exactly DIVIDEND_W RUN cycles.
- FIN, one cycle:
  - Outputs are registered on entry.
  - Normal case: quotient=Q, remainder=R[DIVISOR_W-1:0], div_by_zero=0.
  - Divide-by-zero case: quotient=all ones (8'hFF), remainder=0, div_by_zero=1.
  - done=1 for this cycle only, then return to IDLE.
- Latency:
  - Normal operation: start accepted at edge N, done high in the cycle after edge N+DIVIDEND_W+1, i.e. 10 edges for the defaults.
  - Divide-by-zero: done high after edge N+1.
- Busy and handshake:
  - busy=1 during RUN and 0 otherwise. done and busy are never both high.
  - start while busy=1 or during FIN is ignored: no queuing, and operands are not resampled.
  - start in the same cycle as done (FIN) is ignored. A new start is accepted in the following IDLE cycle.
- Invariant for divisor!=0: quotient*divisor + remainder == dividend, and remainder < divisor.
- Output stability: outputs change only at reset or on the FIN transition. Between operations they hold the last result.

Optional Feature:
- Macro: SEQ_DIVIDER_SELFCHECK_EN.
- Defined:
  - In FIN, for divisor!=0, a combinational check computes quotient*divisor + remainder at 12-bit width and compares it with the latched dividend.
  - The multiply reuses the team's 4x4 Vedic multiplier, two instances over the quotient nibbles.
  - On mismatch, check_err is set to 1 and held until reset (sticky).
  - Divide-by-zero operations are not checked.
- Undefined: no check logic is built and check_err is tied to 0.

Test Plan:
- Reset, then start with dividend=200, divisor=7 → busy high for 8 cycles; done pulses 10 edges after accept; quotient=28, remainder=4, div_by_zero=0.
- dividend=255, divisor=15 → quotient=17, remainder=0. Then dividend=5, divisor=9 → quotient=0, remainder=5. Outputs hold between the two operations.
- dividend=100, divisor=0 → done one edge after FIN entry (2 edges after accept); quotient=8'hFF, remainder=0, div_by_zero=1. A following 100/10 operation clears the flag (quotient=10, remainder=0).
- Start 200/7, then pulse start with 9/3 during RUN and again in the done cycle → both ignored; result is 28 rem 4; the next IDLE start of 9/3 yields 3 rem 0.
- Assert rst_n=0 for one cycle mid-RUN (4th cycle) → next cycle all outputs are 0, there is no done pulse, and IDLE accepts a new start normally.
- With SEQ_DIVIDER_SELFCHECK_EN, run an exhaustive sweep of all 256×15 nonzero-divisor pairs against a reference model → every result matches and check_err stays 0. With the macro off, check_err stays 0 throughout.

Source files
------------

// File: rtl/seq_divider_8_4.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Optional SEQ_DIVIDER_SELFCHECK_EN adds a Vedic-multiplier back-check of each result.
`ifdef SEQ_DIVIDER_SELFCHECK_EN
module seq_divider_vedic_4x4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);
    function automatic logic [3:0] vm2(input logic [1:0] a, input logic [1:0] b);
        logic       c;
        logic [3:0] p;
        p[0] = a[0] & b[0];
        p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
        c    = (a[1] & b[0]) & (a[0] & b[1]);
        p[2] = (a[1] & b[1]) ^ c;
        p[3] = (a[1] & b[1]) & c;
        return p;
    endfunction

    logic [3:0] w_q0, w_q1, w_q2, w_q3;

    assign w_q0 = vm2(i_a[1:0], i_b[1:0]);
    assign w_q1 = vm2(i_a[3:2], i_b[1:0]);
    assign w_q2 = vm2(i_a[1:0], i_b[3:2]);
    assign w_q3 = vm2(i_a[3:2], i_b[3:2]);
    assign o_p  = {4'b0, w_q0} + {2'b0, w_q1, 2'b0} + {2'b0, w_q2, 2'b0} + {w_q3, 4'b0};
endmodule
`endif

module seq_divider_8_4 #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic                  check_err
);
    localparam int RW    = DIVISOR_W + 1;
    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t                r_state, w_state_nxt;
    logic [DIVIDEND_W-1:0] r_q;
    logic [DIVISOR_W-1:0]  r_d;
    logic [RW-1:0]         r_r;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_zero;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_done;
    logic                  r_dbz;
    logic                  w_accept;
    logic [RW-1:0]         w_rt;
    logic                  w_ge;
    logic [RW-1:0]         w_rnext;

    // A start coinciding with the done pulse is dropped; the next IDLE cycle may accept.
    assign w_accept = (r_state == S_IDLE) && start && !r_done;

    // The top bit of R is always zero after a restore step, so the shift simply drops it.
    assign w_rt    = RW'({r_r, r_q[DIVIDEND_W-1]});
    assign w_ge    = (w_rt >= {1'b0, r_d});
    assign w_rnext = w_ge ? (w_rt - {1'b0, r_d}) : w_rt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = (divisor == '0) ? S_FIN : S_RUN;
            S_RUN:  if (r_cnt == '0) w_state_nxt = S_FIN;
            S_FIN:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == S_FIN);
            if (r_state == S_FIN) begin
                if (r_zero) begin
                    r_quotient  <= '1;
                    r_remainder <= '0;
                    r_dbz       <= 1'b1;
                end else begin
                    r_quotient  <= r_q;
                    r_remainder <= r_r[DIVISOR_W-1:0];
                    r_dbz       <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_q    <= dividend;
            r_d    <= divisor;
            r_r    <= '0;
            r_cnt  <= CNT_LAST;
            r_zero <= (divisor == '0);
        end else if (r_state == S_RUN) begin
            r_q   <= {r_q[DIVIDEND_W-2:0], w_ge};
            r_r   <= w_rnext;
            r_cnt <= r_cnt - 1'b1;
        end
    end

`ifdef SEQ_DIVIDER_SELFCHECK_EN
    logic [DIVIDEND_W-1:0] r_dvd;
    logic                  r_check_err;
    logic [7:0]            w_p_lo, w_p_hi;
    logic [11:0]           w_sum;

    always_ff @(posedge clk) begin
        if (w_accept) r_dvd <= dividend;
    end

    seq_divider_vedic_4x4 u_mul_lo (.i_a(r_q[3:0]), .i_b(r_d), .o_p(w_p_lo));
    seq_divider_vedic_4x4 u_mul_hi (.i_a(r_q[7:4]), .i_b(r_d), .o_p(w_p_hi));

    assign w_sum = {4'b0, w_p_lo} + {w_p_hi, 4'b0} + {8'b0, r_r[3:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_check_err <= 1'b0;
        end else if ((r_state == S_FIN) && !r_zero && (w_sum != {4'b0, r_dvd})) begin
            r_check_err <= 1'b1;
        end
    end

    assign check_err = r_check_err;
`else
    assign check_err = 1'b0;
`endif

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign busy        = (r_state == S_RUN);
endmodule
